// File: rtl/avg_pkg.sv
// avg_pkg: AVG opcodes, sequencer state encoding and instruction byte counts
package avg_pkg;
  localparam logic [2:0] OP_VECTOR1 = 3'b000;
  localparam logic [2:0] OP_HALT    = 3'b001;
  localparam logic [2:0] OP_VECTOR2 = 3'b010;
  localparam logic [2:0] OP_STAT    = 3'b011;
  localparam logic [2:0] OP_CENTER  = 3'b100;
  localparam logic [2:0] OP_JSR     = 3'b101;
  localparam logic [2:0] OP_JMP     = 3'b111;
  localparam logic [2:0] OP_RTS     = 3'b110;
  localparam int INST_LONG  = 4;
  localparam int INST_SHORT = 2;
  typedef enum logic [2:0] {IDLE, F0, F1, F2, F3, EXEC, DRAW} state_t;
  function automatic logic [1:0] last_byte(input logic [2:0] op);
    return 2'(op == OP_VECTOR1 ? INST_LONG - 1 : INST_SHORT - 1);
  endfunction
endpackage

// File: rtl/avg_sequencer_if.sv
// avg_sequencer_if: vector memory, decoder and draw handshake bundle of the AVG sequencer
interface avg_sequencer_if;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_data;
  logic [31:0] inst;
  logic        inst_vld;
  logic [2:0]  dcd_pc_offset;
  logic [2:0]  dcd_inst_length;
  logic        dcd_jmp;
  logic        dcd_jsr;
  logic        dcd_ret;
  logic        dcd_halt;
  logic        dcd_vector;
  logic [15:0] dcd_jump_addr;
  logic        draw_start;
  logic        draw_done;
  modport master (
    output mem_addr, mem_rd, inst, inst_vld, draw_start,
    input  mem_data, dcd_pc_offset, dcd_inst_length, dcd_jmp, dcd_jsr, dcd_ret,
           dcd_halt, dcd_vector, dcd_jump_addr, draw_done
  );
  modport slave (
    input  mem_addr, mem_rd, inst, inst_vld, draw_start,
    output mem_data, dcd_pc_offset, dcd_inst_length, dcd_jmp, dcd_jsr, dcd_ret,
           dcd_halt, dcd_vector, dcd_jump_addr, draw_done
  );
endinterface

// File: rtl/avg_ret_stack.sv
// avg_ret_stack: DEPTH x 16 LIFO of JSR return addresses
module avg_ret_stack #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        push,
  input  logic        pop,
  input  logic [15:0] din,
  output logic [15:0] dout,
  output logic        full,
  output logic        empty
);
  localparam int AW = $clog2(DEPTH);
  logic [15:0] mem [DEPTH];
  logic [AW:0] sp;
  assign full  = sp == (AW + 1)'(DEPTH);
  assign empty = sp == '0;
  assign dout  = mem[AW'(sp - 1'b1)];
  always_ff @(posedge clk) begin
    if (rst || clr) sp <= '0;
    else if (push && !full) sp <= sp + 1'b1;
    else if (pop && !empty) sp <= sp - 1'b1;
  end
  always_ff @(posedge clk)
    if (push && !full) mem[sp[AW-1:0]] <= din;
endmodule

// File: rtl/avg_sequencer.sv
// avg_sequencer: AVG fetch/execute controller; define AVG_SEQ_WATCHDOG_EN for the instruction watchdog
module avg_sequencer
  import avg_pkg::*;
#(
  parameter int STACK_DEPTH = 4
`ifdef AVG_SEQ_WATCHDOG_EN
  , parameter logic [15:0] WDOG_LIMIT = 16'd4096
`endif
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            go,
  avg_sequencer_if.master bus,
  output logic [15:0]     pc,
  output logic            halted,
  output logic            err
);
  state_t state, state_n;
  logic [15:0] pc_n, pc_next, top;
  logic [31:0] inst_q;
  logic [1:0]  idx_q, off;
  logic [2:0]  off_q, cnt, rem;
  logic rd_q, rd, err_n, push, pop, clr, full, empty, last, wd_trip, dstart;

  avg_ret_stack #(.DEPTH(STACK_DEPTH)) u_stk (
    .clk(clk), .rst(rst), .clr(clr), .push(push), .pop(pop),
    .din(pc_next), .dout(top), .full(full), .empty(empty)
  );

  assign pc_next        = pc + {13'd0, bus.dcd_pc_offset};
  assign rem            = cnt != 3'd0 ? cnt : bus.dcd_inst_length != 3'd0 ? bus.dcd_inst_length : 3'd1;
  assign last           = rem == 3'd1;
  assign bus.mem_rd     = rd;
  assign bus.mem_addr   = rd ? pc + {14'd0, off} : 16'h0000;
  assign bus.inst       = state == EXEC ? inst_q : 32'h0;
  assign bus.inst_vld   = state == EXEC;
  assign bus.draw_start = dstart;
  assign halted         = state == IDLE;

`ifdef AVG_SEQ_WATCHDOG_EN
  logic [15:0] wd;
  always_ff @(posedge clk) begin
    if (rst || (state == IDLE && go)) wd <= '0;
    else if (state == EXEC && last) wd <= wd + 16'd1;
  end
  assign wd_trip = wd + 16'd1 >= WDOG_LIMIT;
`else
  assign wd_trip = 1'b0;
`endif

  always_comb begin
    state_n = state;
    pc_n    = pc;
    err_n   = err;
    rd      = 1'b0;
    off     = 2'd0;
    push    = 1'b0;
    pop     = 1'b0;
    clr     = 1'b0;
    dstart  = 1'b0;
    case (state)
      IDLE: if (go) begin
        state_n = F0;
        pc_n    = '0;
        err_n   = 1'b0;
        clr     = 1'b1;
      end
      F0: begin
        rd      = 1'b1;
        state_n = F1;
      end
      F1: begin
        rd      = 1'b1;
        off     = 2'd1;
        state_n = F2;
      end
      // mem_data holds the byte at pc+1 here, so the opcode decides the length
      F2: begin
        rd      = last_byte(bus.mem_data[7:5]) != 2'd1;
        off     = 2'd2;
        state_n = rd ? F3 : EXEC;
      end
      // first cycle issues pc+3, second cycle only captures it
      F3: begin
        rd      = idx_q != 2'(INST_LONG - 1);
        off     = 2'd3;
        state_n = rd ? F3 : EXEC;
      end
      EXEC: if (last) begin
        if (wd_trip) begin
          err_n   = 1'b1;
          state_n = IDLE;
        end else if (bus.dcd_halt) state_n = IDLE;
        else if (bus.dcd_vector) begin
          dstart  = 1'b1;
          state_n = DRAW;
        end else if (bus.dcd_jsr) begin
          push    = !full;
          err_n   = err | full;
          pc_n    = full ? pc : bus.dcd_jump_addr;
          state_n = full ? IDLE : F0;
        end else if (bus.dcd_jmp) begin
          pc_n    = bus.dcd_jump_addr;
          state_n = F0;
        end else if (bus.dcd_ret) begin
          pop     = !empty;
          err_n   = err | empty;
          pc_n    = empty ? pc : top;
          state_n = empty ? IDLE : F0;
        end else begin
          pc_n    = pc_next;
          state_n = F0;
        end
      end
      DRAW: if (bus.draw_done) begin
        pc_n    = pc + {13'd0, off_q};
        state_n = F0;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      pc     <= '0;
      err    <= 1'b0;
      rd_q   <= 1'b0;
      idx_q  <= '0;
      inst_q <= '0;
      cnt    <= '0;
      off_q  <= '0;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      err   <= err_n;
      rd_q  <= rd;
      if (rd) idx_q <= off;
      if (state == F0) inst_q <= '0;
      else if (rd_q) inst_q[{~idx_q, 3'b000} +: 8] <= bus.mem_data;
      cnt <= state == EXEC && !last ? rem - 3'd1 : 3'd0;
      if (state == EXEC) off_q <= bus.dcd_pc_offset;
    end
  end
endmodule

// File: tb/tb_avg_sequencer.sv
// tb_avg_sequencer: directed programs against byte memory and a small decoder model
module tb_avg_sequencer;
  logic clk = 1'b0;
  logic rst, go;
  logic [15:0] pc;
  logic halted, err;
  logic [7:0] mem [0:65535];
  logic [15:0] rd_log [$];
  logic [15:0] pc_log [$];
  logic [31:0] inst_log [$];
  int ds_cnt, vld_cyc, errors, checks;
  logic vld_d = 1'b0;
  logic [2:0] op;

  avg_sequencer_if bus ();

`ifdef AVG_SEQ_WATCHDOG_EN
  avg_sequencer #(.STACK_DEPTH(4), .WDOG_LIMIT(16'd8)) dut (
`else
  avg_sequencer #(.STACK_DEPTH(4)) dut (
`endif
    .clk(clk), .rst(rst), .go(go), .bus(bus.master), .pc(pc), .halted(halted), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (bus.mem_rd) bus.mem_data <= mem[bus.mem_addr];

  // decoder model: JSR/JMP target is {inst[20:16], inst[31:24]} scaled to bytes by 8
  always_comb begin
    op                  = bus.inst[23:21];
    bus.dcd_vector      = op == 3'b000;
    bus.dcd_halt        = op == 3'b001;
    bus.dcd_jsr         = op == 3'b101;
    bus.dcd_ret         = op == 3'b110;
    bus.dcd_jmp         = op == 3'b111;
    bus.dcd_pc_offset   = op == 3'b000 ? 3'd4 : 3'd2;
    bus.dcd_inst_length = op == 3'b011 ? 3'd3 : op == 3'b100 ? 3'd0 : 3'd1;
    bus.dcd_jump_addr   = {bus.inst[20:16], bus.inst[31:24], 3'b000};
  end

  always @(negedge clk) begin
    if (bus.mem_rd) rd_log.push_back(bus.mem_addr);
    if (bus.draw_start) ds_cnt++;
    if (bus.inst_vld) vld_cyc++;
    if (bus.inst_vld && !vld_d) begin
      pc_log.push_back(pc);
      inst_log.push_back(bus.inst);
    end
    vld_d = bus.inst_vld;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic start();
    rd_log.delete();
    pc_log.delete();
    inst_log.delete();
    ds_cnt = 0;
    vld_cyc = 0;
    @(negedge clk);
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
  endtask

  task automatic wait_halt(input int lim);
    int n;
    n = 0;
    while (!halted && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk("halt_timeout", halted, 1);
  endtask

  task automatic wait_draw();
    int n;
    n = 0;
    while (!bus.draw_start && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("draw_start_seen", bus.draw_start, 1);
  endtask

  // draw_done is raised in the draw_start cycle (must be ignored) and again d cycles later
  task automatic do_draw(input int d, input logic [15:0] cur_pc, input logic [15:0] exp_pc);
    wait_draw();
    bus.draw_done = 1'b1;
    @(negedge clk);
    bus.draw_done = 1'b0;
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    repeat (d - 2) @(negedge clk);
    chk("draw_wait_pc", pc, cur_pc);
    chk("draw_wait_busy", {halted, bus.mem_rd}, 2'b00);
    bus.draw_done = 1'b1;
    @(negedge clk);
    bus.draw_done = 1'b0;
    chk("draw_done_pc", pc, exp_pc);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    rst = 1'b1;
    go = 1'b0;
    bus.draw_done = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_halted", halted, 1);
    chk("rst_pc", pc, 0);
    chk("rst_err", err, 0);
    chk("rst_mem", {bus.mem_rd, bus.mem_addr}, 0);
    chk("rst_inst", {bus.inst_vld, bus.draw_start}, 0);
    chk("rst_inst_word", bus.inst, 0);
    rst = 1'b0;
    mem[0] = 8'h00; mem[1] = 8'h20;
    start();
    wait_halt(100);
    chk("short_nrd", rd_log.size(), 2);
    chk("short_rd0", rd_log[0], 16'h0000);
    chk("short_rd1", rd_log[1], 16'h0001);
    chk("short_inst", inst_log[0], 32'h0020_0000);
    chk("short_pc", pc, 16'h0000);
    chk("short_vld", vld_cyc, 1);
    mem[0] = 8'h12; mem[1] = 8'h00; mem[2] = 8'h34; mem[3] = 8'h56;
    mem[4] = 8'h00; mem[5] = 8'h20;
    start();
    do_draw(10, 16'h0000, 16'h0004);
    wait_halt(100);
    chk("long_draws", ds_cnt, 1);
    chk("long_pc", pc, 16'h0004);
    chk("long_nrd", rd_log.size(), 6);
    chk("long_rd3", rd_log[3], 16'h0003);
    chk("long_inst", inst_log[0], 32'h1200_3456);
    chk("long_halt_inst", inst_log[1], 32'h0020_0000);
    mem[0] = 8'h20; mem[1] = 8'hA0; mem[16'h100] = 8'h00; mem[16'h101] = 8'hC0;
    mem[2] = 8'h00; mem[3] = 8'h20;
    start();
    wait_halt(200);
    chk("jsr_nexec", pc_log.size(), 3);
    chk("jsr_pc1", pc_log[1], 16'h0100);
    chk("jsr_pc2", pc_log[2], 16'h0002);
    chk("jsr_sp", dut.u_stk.sp, 0);
    chk("jsr_err", err, 0);
    mem[0] = 8'h02; mem[1] = 8'hA0; mem[16'h10] = 8'h04; mem[16'h11] = 8'hA0;
    mem[16'h20] = 8'h06; mem[16'h21] = 8'hA0; mem[16'h30] = 8'h08; mem[16'h31] = 8'hA0;
    mem[16'h40] = 8'h0A; mem[16'h41] = 8'hA0;
    start();
    wait_halt(300);
    chk("ovf_nexec", pc_log.size(), 5);
    chk("ovf_err", err, 1);
    chk("ovf_sp", dut.u_stk.sp, 4);
    chk("ovf_pc", pc, 16'h0040);
    start();
    chk("go_clears_err", err, 0);
    chk("go_clears_sp", dut.u_stk.sp, 0);
    wait_halt(300);
    chk("ovf2_err", err, 1);
    mem[0] = 8'h00; mem[1] = 8'hC0;
    start();
    wait_halt(100);
    chk("udf_err", err, 1);
    chk("udf_sp", dut.u_stk.sp, 0);
    chk("udf_nexec", pc_log.size(), 1);
    mem[0] = 8'h00; mem[1] = 8'h60; mem[2] = 8'h00; mem[3] = 8'h80;
    mem[4] = 8'h00; mem[5] = 8'h20;
    start();
    wait_halt(200);
    chk("len_vld_cycles", vld_cyc, 5);
    chk("len_nexec", pc_log.size(), 3);
    chk("len_pc", pc, 16'h0004);
    chk("len_err", err, 0);
    mem[0] = 8'hFF; mem[1] = 8'hFF;
    mem[16'hFFF8] = 8'h00; mem[16'hFFF9] = 8'h40; mem[16'hFFFA] = 8'h00; mem[16'hFFFB] = 8'h40;
    mem[16'hFFFC] = 8'h00; mem[16'hFFFD] = 8'h40; mem[16'hFFFE] = 8'hAB; mem[16'hFFFF] = 8'h00;
    mem[2] = 8'h00; mem[3] = 8'h20;
    start();
    do_draw(10, 16'hFFFE, 16'h0002);
    wait_halt(200);
    chk("wrap_pc_fffc", pc_log[3], 16'hFFFC);
    chk("wrap_inst", inst_log[4], 32'hAB00_FFFF);
    chk("wrap_rd_ffff", rd_log[9], 16'hFFFF);
    chk("wrap_rd_0000", rd_log[10], 16'h0000);
    chk("wrap_pc_final", pc, 16'h0002);
    mem[0] = 8'h40; mem[1] = 8'hE0;
    mem[16'h200] = 8'h12; mem[16'h201] = 8'h00; mem[16'h202] = 8'h34; mem[16'h203] = 8'h56;
    start();
    wait_draw();
    repeat (2) @(negedge clk);
    chk("mid_draw_pc", pc, 16'h0200);
    chk("mid_draw_busy", halted, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("rstdraw_halted", halted, 1);
    chk("rstdraw_pc", pc, 16'h0000);
    chk("rstdraw_outs", {bus.draw_start, bus.mem_rd, bus.inst_vld}, 3'b000);
    rst = 1'b0;
    rd_log.delete();
    bus.draw_done = 1'b1;
    @(negedge clk);
    bus.draw_done = 1'b0;
    repeat (3) @(negedge clk);
    chk("late_done_nrd", rd_log.size(), 0);
    chk("late_done_halted", halted, 1);
`ifdef AVG_SEQ_WATCHDOG_EN
    mem[0] = 8'h00; mem[1] = 8'hE0;
    start();
    wait_halt(300);
    chk("wdog_err", err, 1);
    chk("wdog_nexec", pc_log.size(), 8);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/avg_sequencer.md
Name: avg_sequencer

Overview:
- Fetch/execute controller for the AVG vector processor.
- Sequences byte-wide reads from vector memory and assembles 16/32-bit AVG instructions for the external decoder (avg_decode).
- Applies the decoded control results: PC advance, JMP/JSR/RTS with a return stack, HALT, and a draw handshake with the vector generator datapath.
- Sits between vector RAM/ROM, the decoder and the vector/scale/Z register datapath.

Parameters:
- STACK_DEPTH, 4, JSR return-stack entries (power of 2, at least 2).
- WDOG_LIMIT, 16'd4096, instructions executed before the watchdog trips (only with the optional feature).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- go  in  1  1-cycle pulse: start program at address 16'h0000
- mem_addr  out  16  byte address to vector memory
- mem_rd  out  1  read strobe; mem_data is valid exactly 1 cycle later
- mem_data  in  8  read data
- inst  out  32  assembled instruction to decoder; 0 when not in EXEC
- inst_vld  out  1  inst is stable; decoder outputs are sampled this cycle
- dcd_pc_offset  in  3  from decoder: 2 or 4
- dcd_jmp, dcd_jsr, dcd_ret, dcd_halt, dcd_vector  in  1 each  decoder controls
- dcd_jump_addr  in  16  decoder jump target (byte address)
- dcd_inst_length  in  3  decoder execute-cycle count
- draw_start  out  1  1-cycle pulse: datapath begins the vector
- draw_done  in  1  datapath finished the vector (level or pulse)
- pc  out  16  current instruction byte address
- halted  out  1  sequencer in IDLE
- err  out  1  sticky: stack overflow/underflow or watchdog trip; cleared by go or rst

Behaviour:
- Reset values: state IDLE, pc=0, sp=0, mem_rd=0, mem_addr=0, inst=0, inst_vld=0, draw_start=0, halted=1, err=0.
- Byte mapping: inst[31:24]=mem[pc], inst[23:16]=mem[pc+1], inst[15:8]=mem[pc+2], inst[7:0]=mem[pc+3].
- Opcode field: inst[23:21]. An opcode of OP_VECTOR1 (3'b000) is the long form and needs 4 bytes; every other opcode needs 2 bytes. Unfetched bytes are 0.
- States:
  - IDLE: wait for go. On go: pc=0, sp=0, err=0, go to F0.
  - F0/F1/F2/F3: issue one byte read per state at mem_addr=pc+n. Capture mem_data the following cycle, pipelined so that one read issues per cycle.
  - After the byte at pc+1 is captured: if inst[23:21]!=3'b000, skip F2/F3.
  - Short form: last byte captured 2 cycles after F0. Long form: 4 cycles after F0.
  - EXEC: inst_vld=1 for the whole state. Load cycle counter = dcd_inst_length and count down to 1, with a minimum of 1 cycle. Then resolve, in priority order:
    1. halt: go to IDLE. pc holds the HALT address.
    2. vector: pulse draw_start and go to DRAW.
    3. jsr: push pc+dcd_pc_offset, pc=dcd_jump_addr.
    4. jmp (without jsr): pc=dcd_jump_addr.
    5. ret: pop into pc.
    6. otherwise: pc=pc+dcd_pc_offset, with 16-bit wrap.
    After cases 3-6, go to F0.
  - DRAW: wait for draw_done. Then pc=pc+dcd_pc_offset (latched in EXEC) and go to F0. A draw_done already high in the draw_start cycle is ignored; it is sampled from the next cycle on.
- Stack errors:
  - JSR with sp==STACK_DEPTH: set err, go to IDLE, no push.
  - RTS with sp==0: set err, go to IDLE.
- go outside IDLE is ignored. rst in any state returns everything to reset values in the next cycle, including mid-fetch and mid-draw.
- Address arithmetic is modulo 2^16. The fetch at 16'hFFFF+1 reads 16'h0000.

Optional Feature:
- Macro: AVG_SEQ_WATCHDOG_EN.
- With the macro: a 16-bit counter increments per EXEC exit and clears on go. Reaching WDOG_LIMIT forces IDLE with err=1 at the next EXEC exit.
- Without the macro: no counter exists and a program never self-terminates without a HALT.

Decomposition:
- avg_pkg holds:
  - opcode localparams OP_VECTOR1..OP_RTS;
  - the state enum typedef (IDLE, F0, F1, F2, F3, EXEC, DRAW);
  - the INST_LONG/INST_SHORT byte counts.
- Sub-module avg_ret_stack: STACK_DEPTH x 16 LIFO with push, pop, full and empty.

Test Plan:
- Short-form program:
  - Stimulus: mem[0..1]=8'h00,8'h20 (op=001, HALT class) and go.
  - Required: mem_rd at addresses 0 and 1 only, EXEC with inst=32'h0020_0000, halted=1, pc=0.
- Long vector:
  - Stimulus: 4-byte VECTOR1 at 0, decoder vector=1, pc_offset=4, draw_done 10 cycles after draw_start, then HALT at 4.
  - Required: exactly one draw_start, pc=4 after draw_done, halted=1.
- JSR/RTS:
  - Stimulus: JSR at 0 to 16'h0100, RTS at 16'h0100, HALT at 2.
  - Required: pc sequence 0, 0x100, 2; sp returns to 0; err=0.
- Stack overflow:
  - Stimulus: STACK_DEPTH+1 nested JSRs.
  - Required: err=1 and IDLE after the 5th JSR (STACK_DEPTH=4); sp=4.
- Reset mid-draw:
  - Stimulus: rst asserted while in DRAW.
  - Required: next cycle state IDLE, halted=1, pc=0, draw_start=0. A late draw_done is ignored.
- Watchdog (macro defined, WDOG_LIMIT=8):
  - Stimulus: JMP-to-self at 0.
  - Required: err=1 and IDLE after the 8th EXEC.
